// File: rtl/seq_control_unit.sv
// seq_control_unit: handshaked, stall-aware multi-cycle sequencer for the
// 16-bit MSP430-style core. It fetches over a req/valid handshake, decodes
// register-mode double-operand ALU ops and the eight conditional jumps, and
// issues one-cycle ALU, write-back and PC strobes. Every output is driven
// straight from a register. While stall is high every register holds, so a
// strobe stays asserted; downstream consumers must qualify strobes with !stall.
module seq_control_unit #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 4,
    parameter int ALU_OP_W   = 5,
    parameter int OFFSET_W   = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  stall,
    output logic                  instr_req,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic [3:0]            flags,
    output logic [REG_ADDR_W-1:0] src_reg,
    output logic [REG_ADDR_W-1:0] dst_reg,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [ALU_OP_W-1:0]   op_code,
    output logic                  alu_en,
    output logic                  wr_en,
    output logic                  byte_op,
    output logic                  pc_inc,
    output logic                  branch_en,
    output logic [OFFSET_W-1:0]   pc_offset,
    output logic                  illegal_op,
    output logic [5:0]            fsm_state,
    output logic [CNT_W-1:0]      retired
);

    // One-hot state encoding; the state register doubles as the fsm_state output.
    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_FETCH  = 6'b000010;
    localparam logic [5:0] ST_DECODE = 6'b000100;
    localparam logic [5:0] ST_EXEC   = 6'b001000;
    localparam logic [5:0] ST_WB     = 6'b010000;
    localparam logic [5:0] ST_BRANCH = 6'b100000;

    // Instruction class captured at fetch time.
    localparam logic [1:0] KIND_ILL = 2'b00;
    localparam logic [1:0] KIND_ALU = 2'b01;
    localparam logic [1:0] KIND_JMP = 2'b10;

    localparam logic [ALU_OP_W-1:0] OP_NONE  = {ALU_OP_W{1'b1}};
    localparam logic [3:0]          OPC_BASE = 4'h4;
    localparam logic [3:0]          OPC_CMP  = 4'h9;
    localparam logic [3:0]          OPC_BIT  = 4'hB;

    // Classify an instruction from its opcode and addressing-mode bits.
    // Only register-to-register double-operand forms are executable.
    function automatic logic [1:0] classify_instr(
        input logic [3:0] opc,
        input logic       ad,
        input logic [1:0] as_mode
    );
        logic [1:0] kind;
        case (opc)
            4'h0, 4'h1: kind = KIND_ILL;
            4'h2, 4'h3: kind = KIND_JMP;
            default: begin
                if ((ad == 1'b0) && (as_mode == 2'b00)) begin
                    kind = KIND_ALU;
                end else begin
                    kind = KIND_ILL;
                end
            end
        endcase
        return kind;
    endfunction

    // Evaluate a jump condition against {V,N,C,Z}.
    function automatic logic cond_holds(input logic [2:0] cond, input logic [3:0] flg);
        logic v;
        logic n;
        logic c;
        logic z;
        logic taken;
        v = flg[3];
        n = flg[2];
        c = flg[1];
        z = flg[0];
        case (cond)
            3'b000:  taken = (z == 1'b0);
            3'b001:  taken = (z == 1'b1);
            3'b010:  taken = (c == 1'b0);
            3'b011:  taken = (c == 1'b1);
            3'b100:  taken = (n == 1'b1);
            3'b101:  taken = ((n ^ v) == 1'b0);
            3'b110:  taken = ((n ^ v) == 1'b1);
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Architectural registers.
    logic [5:0]            state_r;
    logic                  instr_req_r;
    logic [REG_ADDR_W-1:0] src_reg_r;
    logic [REG_ADDR_W-1:0] dst_reg_r;
    logic [REG_ADDR_W-1:0] wr_reg_r;
    logic [ALU_OP_W-1:0]   op_code_r;
    logic                  alu_en_r;
    logic                  wr_en_r;
    logic                  byte_op_r;
    logic                  pc_inc_r;
    logic                  branch_en_r;
    logic [OFFSET_W-1:0]   pc_offset_r;
    logic                  illegal_op_r;
    logic [CNT_W-1:0]      retired_r;
    logic [3:0]            opc_r;
    logic [2:0]            cond_r;
    logic [1:0]            kind_r;

    // Next-state values.
    logic [5:0]            state_nxt_s;
    logic                  instr_req_nxt_s;
    logic [REG_ADDR_W-1:0] src_reg_nxt_s;
    logic [REG_ADDR_W-1:0] dst_reg_nxt_s;
    logic [REG_ADDR_W-1:0] wr_reg_nxt_s;
    logic [ALU_OP_W-1:0]   op_code_nxt_s;
    logic                  alu_en_nxt_s;
    logic                  wr_en_nxt_s;
    logic                  byte_op_nxt_s;
    logic                  pc_inc_nxt_s;
    logic                  branch_en_nxt_s;
    logic [OFFSET_W-1:0]   pc_offset_nxt_s;
    logic                  illegal_op_nxt_s;
    logic [CNT_W-1:0]      retired_nxt_s;
    logic [3:0]            opc_nxt_s;
    logic [2:0]            cond_nxt_s;
    logic [1:0]            kind_nxt_s;

    // Fields of the instruction on the fetch bus, decoded as it is accepted so
    // the decode outputs are already registered during the DECODE cycle.
    logic [3:0] fetch_opc_s;
    logic [1:0] fetch_kind_s;
    logic       accept_s;

    assign fetch_opc_s  = instruction[INSTR_W-1 -: 4];
    assign fetch_kind_s = classify_instr(fetch_opc_s, instruction[7], instruction[5:4]);
    assign accept_s     = instr_req_r && instr_valid;

    // Sequencer next-state and strobe generation; strobes default low each step.
    always_comb begin
        state_nxt_s      = state_r;
        instr_req_nxt_s  = instr_req_r;
        src_reg_nxt_s    = src_reg_r;
        dst_reg_nxt_s    = dst_reg_r;
        wr_reg_nxt_s     = wr_reg_r;
        op_code_nxt_s    = op_code_r;
        byte_op_nxt_s    = byte_op_r;
        pc_offset_nxt_s  = pc_offset_r;
        retired_nxt_s    = retired_r;
        opc_nxt_s        = opc_r;
        cond_nxt_s       = cond_r;
        kind_nxt_s       = kind_r;
        alu_en_nxt_s     = 1'b0;
        wr_en_nxt_s      = 1'b0;
        pc_inc_nxt_s     = 1'b0;
        branch_en_nxt_s  = 1'b0;
        illegal_op_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s     = ST_FETCH;
                    instr_req_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_IDLE;
                    instr_req_nxt_s = 1'b0;
                end
            end

            ST_FETCH: begin
                if (accept_s) begin
                    state_nxt_s     = ST_DECODE;
                    instr_req_nxt_s = 1'b0;
                    pc_inc_nxt_s    = 1'b1;
                    opc_nxt_s       = fetch_opc_s;
                    cond_nxt_s      = instruction[12:10];
                    kind_nxt_s      = fetch_kind_s;
                    case (fetch_kind_s)
                        KIND_ALU: begin
                            op_code_nxt_s = ALU_OP_W'(fetch_opc_s - OPC_BASE);
                            src_reg_nxt_s = REG_ADDR_W'(instruction[11:8]);
                            dst_reg_nxt_s = REG_ADDR_W'(instruction[3:0]);
                            wr_reg_nxt_s  = REG_ADDR_W'(instruction[3:0]);
                            byte_op_nxt_s = instruction[6];
                        end
                        KIND_JMP: begin
                            op_code_nxt_s   = OP_NONE;
                            byte_op_nxt_s   = 1'b0;
                            pc_offset_nxt_s = instruction[OFFSET_W-1:0];
                        end
                        default: begin
                            op_code_nxt_s    = OP_NONE;
                            byte_op_nxt_s    = 1'b0;
                            illegal_op_nxt_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s     = ST_FETCH;
                    instr_req_nxt_s = 1'b1;
                end
            end

            ST_DECODE: begin
                case (kind_r)
                    KIND_ALU: begin
                        state_nxt_s  = ST_EXEC;
                        alu_en_nxt_s = 1'b1;
                    end
                    KIND_JMP: begin
                        // Flags are sampled here; the count is bumped on entry
                        // to BRANCH so it is visible alongside branch_en.
                        state_nxt_s     = ST_BRANCH;
                        branch_en_nxt_s = cond_holds(cond_r, flags);
                        retired_nxt_s   = retired_r + CNT_W'(1);
                    end
                    default: begin
                        if (run) begin
                            state_nxt_s     = ST_FETCH;
                            instr_req_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s     = ST_IDLE;
                            instr_req_nxt_s = 1'b0;
                        end
                    end
                endcase
            end

            ST_EXEC: begin
                // CMP and BIT only update flags, so no register write-back.
                state_nxt_s   = ST_WB;
                wr_en_nxt_s   = (opc_r != OPC_CMP) && (opc_r != OPC_BIT);
                retired_nxt_s = retired_r + CNT_W'(1);
            end

            ST_WB, ST_BRANCH: begin
                if (run) begin
                    state_nxt_s     = ST_FETCH;
                    instr_req_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_IDLE;
                    instr_req_nxt_s = 1'b0;
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                instr_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; stall freezes everything, reset clears at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            instr_req_r  <= 1'b0;
            src_reg_r    <= {REG_ADDR_W{1'b0}};
            dst_reg_r    <= {REG_ADDR_W{1'b0}};
            wr_reg_r     <= {REG_ADDR_W{1'b0}};
            op_code_r    <= OP_NONE;
            alu_en_r     <= 1'b0;
            wr_en_r      <= 1'b0;
            byte_op_r    <= 1'b0;
            pc_inc_r     <= 1'b0;
            branch_en_r  <= 1'b0;
            pc_offset_r  <= {OFFSET_W{1'b0}};
            illegal_op_r <= 1'b0;
            retired_r    <= {CNT_W{1'b0}};
            opc_r        <= 4'h0;
            cond_r       <= 3'b000;
            kind_r       <= KIND_ILL;
        end else if (!stall) begin
            state_r      <= state_nxt_s;
            instr_req_r  <= instr_req_nxt_s;
            src_reg_r    <= src_reg_nxt_s;
            dst_reg_r    <= dst_reg_nxt_s;
            wr_reg_r     <= wr_reg_nxt_s;
            op_code_r    <= op_code_nxt_s;
            alu_en_r     <= alu_en_nxt_s;
            wr_en_r      <= wr_en_nxt_s;
            byte_op_r    <= byte_op_nxt_s;
            pc_inc_r     <= pc_inc_nxt_s;
            branch_en_r  <= branch_en_nxt_s;
            pc_offset_r  <= pc_offset_nxt_s;
            illegal_op_r <= illegal_op_nxt_s;
            retired_r    <= retired_nxt_s;
            opc_r        <= opc_nxt_s;
            cond_r       <= cond_nxt_s;
            kind_r       <= kind_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign fsm_state  = state_r;
    assign instr_req  = instr_req_r;
    assign src_reg    = src_reg_r;
    assign dst_reg    = dst_reg_r;
    assign wr_reg     = wr_reg_r;
    assign op_code    = op_code_r;
    assign alu_en     = alu_en_r;
    assign wr_en      = wr_en_r;
    assign byte_op    = byte_op_r;
    assign pc_inc     = pc_inc_r;
    assign branch_en  = branch_en_r;
    assign pc_offset  = pc_offset_r;
    assign illegal_op = illegal_op_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit. A second instance with a 4-bit
// retired counter exercises counter wrap-around in a few dozen cycles.
module tb_seq_control_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic        run_w;
    logic        stall;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [3:0]  flags;

    logic        instr_req;
    logic [3:0]  src_reg;
    logic [3:0]  dst_reg;
    logic [3:0]  wr_reg;
    logic [4:0]  op_code;
    logic        alu_en;
    logic        wr_en;
    logic        byte_op;
    logic        pc_inc;
    logic        branch_en;
    logic [9:0]  pc_offset;
    logic        illegal_op;
    logic [5:0]  fsm_state;
    logic [15:0] retired;

    logic        w_instr_req;
    logic [3:0]  w_src_reg;
    logic [3:0]  w_dst_reg;
    logic [3:0]  w_wr_reg;
    logic [4:0]  w_op_code;
    logic        w_alu_en;
    logic        w_wr_en;
    logic        w_byte_op;
    logic        w_pc_inc;
    logic        w_branch_en;
    logic [9:0]  w_pc_offset;
    logic        w_illegal_op;
    logic [5:0]  w_fsm_state;
    logic [3:0]  w_retired;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_ret;

    seq_control_unit dut (
        .clk(clk), .rst(rst), .run(run), .stall(stall),
        .instr_req(instr_req), .instr_valid(instr_valid), .instruction(instruction),
        .flags(flags), .src_reg(src_reg), .dst_reg(dst_reg), .wr_reg(wr_reg),
        .op_code(op_code), .alu_en(alu_en), .wr_en(wr_en), .byte_op(byte_op),
        .pc_inc(pc_inc), .branch_en(branch_en), .pc_offset(pc_offset),
        .illegal_op(illegal_op), .fsm_state(fsm_state), .retired(retired)
    );

    seq_control_unit #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .run(run_w), .stall(stall),
        .instr_req(w_instr_req), .instr_valid(instr_valid), .instruction(instruction),
        .flags(flags), .src_reg(w_src_reg), .dst_reg(w_dst_reg), .wr_reg(w_wr_reg),
        .op_code(w_op_code), .alu_en(w_alu_en), .wr_en(w_wr_en), .byte_op(w_byte_op),
        .pc_inc(w_pc_inc), .branch_en(w_branch_en), .pc_offset(w_pc_offset),
        .illegal_op(w_illegal_op), .fsm_state(w_fsm_state), .retired(w_retired)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects FETCH with instr_req high on entry; leaves the DUT in FETCH again.
    task automatic run_alu(input logic [15:0] ins, input logic [4:0] e_op,
                           input logic [3:0] e_src, input logic [3:0] e_dst,
                           input logic e_byte, input logic e_wr);
        instruction = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_eq("alu_dec_state", fsm_state, 6'b000100);
        check_eq("alu_dec_pc_inc", pc_inc, 1'b1);
        check_eq("alu_dec_req", instr_req, 1'b0);
        check_eq("alu_dec_op", op_code, e_op);
        check_eq("alu_dec_src", src_reg, e_src);
        check_eq("alu_dec_dst", dst_reg, e_dst);
        check_eq("alu_dec_wr_reg", wr_reg, e_dst);
        check_eq("alu_dec_byte", byte_op, e_byte);
        check_eq("alu_dec_illegal", illegal_op, 1'b0);
        tick();
        check_eq("alu_exec_state", fsm_state, 6'b001000);
        check_eq("alu_exec_alu_en", alu_en, 1'b1);
        check_eq("alu_exec_pc_inc", pc_inc, 1'b0);
        check_eq("alu_exec_wr_en", wr_en, 1'b0);
        tick();
        exp_ret = exp_ret + 16'd1;
        check_eq("alu_wb_state", fsm_state, 6'b010000);
        check_eq("alu_wb_wr_en", wr_en, e_wr);
        check_eq("alu_wb_alu_en", alu_en, 1'b0);
        check_eq("alu_wb_retired", retired, exp_ret);
        check_eq("alu_wb_req", instr_req, 1'b0);
        tick();
        check_eq("alu_next_state", fsm_state, 6'b000010);
        check_eq("alu_next_req", instr_req, 1'b1);
        check_eq("alu_next_wr_en", wr_en, 1'b0);
    endtask

    task automatic run_jump(input logic [15:0] ins, input logic [3:0] flg,
                            input logic e_br, input logic [9:0] e_off);
        flags       = flg;
        instruction = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_eq("jmp_dec_state", fsm_state, 6'b000100);
        check_eq("jmp_dec_pc_inc", pc_inc, 1'b1);
        check_eq("jmp_dec_offset", pc_offset, e_off);
        check_eq("jmp_dec_op", op_code, 5'h1f);
        check_eq("jmp_dec_illegal", illegal_op, 1'b0);
        tick();
        exp_ret = exp_ret + 16'd1;
        check_eq("jmp_br_state", fsm_state, 6'b100000);
        check_eq("jmp_br_branch_en", branch_en, e_br);
        check_eq("jmp_br_pc_inc", pc_inc, 1'b0);
        check_eq("jmp_br_alu_en", alu_en, 1'b0);
        check_eq("jmp_br_retired", retired, exp_ret);
        tick();
        check_eq("jmp_next_state", fsm_state, 6'b000010);
        check_eq("jmp_next_req", instr_req, 1'b1);
        check_eq("jmp_next_branch_en", branch_en, 1'b0);
    endtask

    task automatic run_illegal(input logic [15:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_eq("ill_dec_state", fsm_state, 6'b000100);
        check_eq("ill_dec_illegal", illegal_op, 1'b1);
        check_eq("ill_dec_pc_inc", pc_inc, 1'b1);
        check_eq("ill_dec_op", op_code, 5'h1f);
        tick();
        check_eq("ill_next_state", fsm_state, 6'b000010);
        check_eq("ill_next_req", instr_req, 1'b1);
        check_eq("ill_next_illegal", illegal_op, 1'b0);
        check_eq("ill_next_alu_en", alu_en, 1'b0);
        check_eq("ill_next_wr_en", wr_en, 1'b0);
        check_eq("ill_next_retired", retired, exp_ret);
    endtask

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Directed stimulus sequence.
    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_ret     = 16'd0;
        rst         = 1'b1;
        run         = 1'b0;
        run_w       = 1'b0;
        stall       = 1'b0;
        instr_valid = 1'b0;
        instruction = 16'h0000;
        flags       = 4'b0000;
        #2;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset state.
        check_eq("rst_state", fsm_state, 6'b000001);
        check_eq("rst_req", instr_req, 1'b0);
        check_eq("rst_op", op_code, 5'h1f);
        check_eq("rst_retired", retired, 16'h0000);
        check_eq("rst_strobes", {alu_en, wr_en, pc_inc, branch_en, illegal_op, byte_op}, 6'b000000);
        check_eq("rst_regs", {src_reg, dst_reg, wr_reg}, 12'h000);
        check_eq("rst_offset", pc_offset, 10'h000);

        // Reset in the middle of FETCH drops the request before any clock edge.
        run = 1'b1;
        tick();
        check_eq("fetch_state", fsm_state, 6'b000010);
        check_eq("fetch_req", instr_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_req", instr_req, 1'b0);
        check_eq("async_rst_state", fsm_state, 6'b000001);
        run = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_eq("post_rst_idle", fsm_state, 6'b000001);

        // ADD R3,R4 offered on the first request.
        run = 1'b1;
        tick();
        check_eq("add_fetch_req", instr_req, 1'b1);
        run_alu(16'h5304, 5'h01, 4'h3, 4'h4, 1'b0, 1'b1);

        // JEQ +5 taken and not taken, then the remaining conditions.
        run_jump(16'h2405, 4'b0001, 1'b1, 10'h005);
        run_jump(16'h2405, 4'b0000, 1'b0, 10'h005);
        run_jump(16'h2000, 4'b0000, 1'b1, 10'h000); // JNE, Z=0
        run_jump(16'h2800, 4'b0010, 1'b0, 10'h000); // JNC, C=1
        run_jump(16'h2C00, 4'b0010, 1'b1, 10'h000); // JC,  C=1
        run_jump(16'h3000, 4'b1000, 1'b0, 10'h000); // JN,  N=0
        run_jump(16'h3400, 4'b0100, 1'b0, 10'h000); // JGE, N^V=1
        run_jump(16'h3800, 4'b0100, 1'b1, 10'h000); // JL,  N^V=1
        run_jump(16'h3400, 4'b1100, 1'b1, 10'h000); // JGE, N^V=0

        // Flag-only ops, other ALU ops, illegal encodings.
        run_alu(16'h9304, 5'h05, 4'h3, 4'h4, 1'b0, 1'b0); // CMP
        run_illegal(16'h4314);                            // As=01
        run_illegal(16'h0000);
        run_alu(16'hB506, 5'h07, 4'h5, 4'h6, 1'b0, 1'b0); // BIT
        run_alu(16'hF00A, 5'h0B, 4'h0, 4'hA, 1'b0, 1'b1); // AND
        run_alu(16'h8103, 5'h04, 4'h1, 4'h3, 1'b0, 1'b1); // SUB
        run_illegal(16'h4384);                            // Ad=1

        // A handshake under stall is not accepted.
        flags       = 4'b0000;
        stall       = 1'b1;
        instruction = 16'h3FFF;
        instr_valid = 1'b1;
        tick();
        check_eq("stall_fetch_state", fsm_state, 6'b000010);
        check_eq("stall_fetch_req", instr_req, 1'b1);
        check_eq("stall_fetch_pc_inc", pc_inc, 1'b0);
        stall = 1'b0;
        tick();
        instr_valid = 1'b0;
        check_eq("jmp_full_state", fsm_state, 6'b000100);
        check_eq("jmp_full_offset", pc_offset, 10'h3FF);
        tick();
        exp_ret = exp_ret + 16'd1;
        check_eq("jmp_full_branch", branch_en, 1'b1);
        check_eq("jmp_full_retired", retired, exp_ret);
        tick();
        check_eq("jmp_full_next_req", instr_req, 1'b1);

        // Stall during EXEC holds alu_en; run falls mid-instruction.
        instruction = 16'h5344;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check_eq("addb_dec_byte", byte_op, 1'b1);
        check_eq("addb_dec_op", op_code, 5'h01);
        tick();
        check_eq("addb_exec_alu_en", alu_en, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_exec_alu_en", alu_en, 1'b1);
            check_eq("stall_exec_state", fsm_state, 6'b001000);
            check_eq("stall_exec_retired", retired, exp_ret);
            check_eq("stall_exec_wr_en", wr_en, 1'b0);
        end
        run   = 1'b0;
        stall = 1'b0;
        tick();
        exp_ret = exp_ret + 16'd1;
        check_eq("addb_wb_state", fsm_state, 6'b010000);
        check_eq("addb_wb_wr_en", wr_en, 1'b1);
        check_eq("addb_wb_alu_en", alu_en, 1'b0);
        check_eq("addb_wb_retired", retired, exp_ret);
        tick();
        check_eq("run_low_idle", fsm_state, 6'b000001);
        check_eq("run_low_req", instr_req, 1'b0);
        tick();
        check_eq("run_low_stay_idle", fsm_state, 6'b000001);

        // Counter wrap on the 4-bit instance using back-to-back JMPs.
        check_eq("w_idle", w_fsm_state, 6'b000001);
        check_eq("w_retired0", w_retired, 4'h0);
        run_w       = 1'b1;
        instruction = 16'h3C00;
        instr_valid = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] kk;
            kk = k[3:0];
            tick();
            tick();
            check_eq("w_retired", w_retired, kk);
            check_eq("w_branch_en", w_branch_en, 1'b1);
            tick();
        end
        run_w       = 1'b0;
        instr_valid = 1'b0;
        tick();
        check_eq("w_wrapped", w_retired, 4'h0);
        check_eq("main_idle_during_w", fsm_state, 6'b000001);
        check_eq("main_retired_during_w", retired, exp_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
